// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and control unit.
//
// Purpose:
//   Watches the write-back descriptors carried by the EX and MEM stage
//   registers and the source operands of the instruction in ID. It drives
//   the en/clear pair of the four stage registers and the PC enable. It
//   produces registered ID/EX forwarding selects and keeps saturating
//   hazard statistics.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   id_req_a/b, id_use_a/b       ID source registers and their use flags
//   ex_regfile_w_en/req_w        EX producer descriptor
//   ex_r_datamem                 EX instruction is a load
//   mem_regfile_w_en/req_w       MEM producer descriptor
//   mem_dmem_access, dmem_ready  data-memory access in MEM and its completion
//   branch_taken                 taken branch/jump resolved in EX
//   halt                         halt instruction reached WB
//   clr_stats                    synchronous clear of the statistics
//   pc_en, psN_en, psN_clear     PC and stage-register controls (combinational)
//   fwd_a, fwd_b                 registered operand selects (0 RF, 1 MEM, 2 WB)
//   halted                       unit is in the HALTED state
//   stall_cycles, flush_count,
//   freeze_cycles                saturating statistics counters
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_req_a,
  input  logic [REG_W-1:0] id_req_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             ex_regfile_w_en,
  input  logic [REG_W-1:0] ex_regfile_req_w,
  input  logic             ex_r_datamem,
  input  logic             mem_regfile_w_en,
  input  logic [REG_W-1:0] mem_regfile_req_w,
  input  logic             mem_dmem_access,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  input  logic             halt,
  input  logic             clr_stats,
  output logic             pc_en,
  output logic             ps1_en,
  output logic             ps2_en,
  output logic             ps3_en,
  output logic             ps4_en,
  output logic             ps1_clear,
  output logic             ps2_clear,
  output logic             ps3_clear,
  output logic             ps4_clear,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_cycles
);

  localparam int unsigned FWD_W = 2;
  localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'd1;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [FWD_W-1:0] fwd_a_q, fwd_a_d;
  logic [FWD_W-1:0] fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_q, flush_q, freeze_q;
  logic             stall_inc, flush_inc, freeze_inc;

  logic ex_haz_a, ex_haz_b, mem_haz_a, mem_haz_b;
  logic freeze_c, load_use_c;

  // Producer/consumer matching; r0 is hard-wired and never forwards.
  // A WB producer needs nothing: the register file writes before it reads.
  always_comb begin
    ex_haz_a  = id_use_a && ex_regfile_w_en && (ex_regfile_req_w != '0)
                && (ex_regfile_req_w == id_req_a);
    ex_haz_b  = id_use_b && ex_regfile_w_en && (ex_regfile_req_w != '0)
                && (ex_regfile_req_w == id_req_b);
    mem_haz_a = id_use_a && mem_regfile_w_en && (mem_regfile_req_w != '0)
                && (mem_regfile_req_w == id_req_a);
    mem_haz_b = id_use_b && mem_regfile_w_en && (mem_regfile_req_w != '0)
                && (mem_regfile_req_w == id_req_b);
  end

  // The first wait cycle must already freeze, so this is not gated by state.
  assign freeze_c   = mem_dmem_access && !dmem_ready;
  // Load data only exists at the end of MEM: the consumer must wait one cycle.
  assign load_use_c = ex_r_datamem && (ex_haz_a || ex_haz_b);

  // Next-state, pipeline controls and forwarding selects, highest priority first.
  always_comb begin
    state_d    = state_q;
    fwd_a_d    = fwd_a_q;
    fwd_b_d    = fwd_b_q;
    pc_en      = 1'b0;
    ps1_en     = 1'b0;
    ps2_en     = 1'b0;
    ps3_en     = 1'b0;
    ps4_en     = 1'b0;
    ps1_clear  = 1'b0;
    ps2_clear  = 1'b0;
    ps3_clear  = 1'b0;
    ps4_clear  = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    freeze_inc = 1'b0;

    if (state_q == ST_HALTED) begin
      state_d = ST_HALTED;
    end else if (halt) begin
      state_d = ST_HALTED;
    end else if (freeze_c) begin
      state_d    = ST_MEMWAIT;
      freeze_inc = 1'b1;
    end else begin
      state_d = ST_RUN;
      if (branch_taken) begin
        // Squash the two younger instructions; older ones drain.
        pc_en     = 1'b1;
        ps1_clear = 1'b1;
        ps2_clear = 1'b1;
        ps3_en    = 1'b1;
        ps4_en    = 1'b1;
        fwd_a_d   = FWD_RF;
        fwd_b_d   = FWD_RF;
        flush_inc = 1'b1;
      end else if (load_use_c) begin
        // Hold PC and IF/ID; a bubble enters EX behind the load.
        ps2_clear = 1'b1;
        ps3_en    = 1'b1;
        ps4_en    = 1'b1;
        fwd_a_d   = FWD_RF;
        fwd_b_d   = FWD_RF;
        stall_inc = 1'b1;
      end else begin
        pc_en  = 1'b1;
        ps1_en = 1'b1;
        ps2_en = 1'b1;
        ps3_en = 1'b1;
        ps4_en = 1'b1;
        // The EX producer is the younger one, so it wins over MEM.
        if (ex_haz_a)       fwd_a_d = FWD_MEM;
        else if (mem_haz_a) fwd_a_d = FWD_WB;
        else                fwd_a_d = FWD_RF;
        if (ex_haz_b)       fwd_b_d = FWD_MEM;
        else if (mem_haz_b) fwd_b_d = FWD_WB;
        else                fwd_b_d = FWD_RF;
      end
    end

    // Keep every stage register still while reset is held.
    if (!rst_n) begin
      pc_en     = 1'b0;
      ps1_en    = 1'b0;
      ps2_en    = 1'b0;
      ps3_en    = 1'b0;
      ps4_en    = 1'b0;
      ps1_clear = 1'b0;
      ps2_clear = 1'b0;
      ps3_clear = 1'b0;
      ps4_clear = 1'b0;
    end
  end

  // State and forwarding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  // Saturating statistics; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else if (clr_stats) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (stall_inc)  stall_q  <= sat_inc(stall_q);
      if (flush_inc)  flush_q  <= sat_inc(flush_q);
      if (freeze_inc) freeze_q <= sat_inc(freeze_q);
    end
  end

  assign fwd_a         = fwd_a_q;
  assign fwd_b         = fwd_b_q;
  assign halted        = (state_q == ST_HALTED);
  assign stall_cycles  = stall_q;
  assign flush_count   = flush_q;
  assign freeze_cycles = freeze_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  localparam int unsigned CW = 16;
  localparam int unsigned RW = 5;

  // Expected {pc_en, ps1..4_en, ps1..4_clear} patterns.
  localparam logic [8:0] CTL_NORMAL = 9'b1_1111_0000;
  localparam logic [8:0] CTL_NONE   = 9'b0_0000_0000;
  localparam logic [8:0] CTL_FLUSH  = 9'b1_0011_1100;
  localparam logic [8:0] CTL_LDUSE  = 9'b0_0011_0100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_req_a, id_req_b;
  logic          id_use_a, id_use_b;
  logic          ex_regfile_w_en;
  logic [RW-1:0] ex_regfile_req_w;
  logic          ex_r_datamem;
  logic          mem_regfile_w_en;
  logic [RW-1:0] mem_regfile_req_w;
  logic          mem_dmem_access, dmem_ready;
  logic          branch_taken, halt, clr_stats;
  logic          pc_en, ps1_en, ps2_en, ps3_en, ps4_en;
  logic          ps1_clear, ps2_clear, ps3_clear, ps4_clear;
  logic [1:0]    fwd_a, fwd_b;
  logic          halted;
  logic [CW-1:0] stall_cycles, flush_count, freeze_cycles;
  logic [8:0]    ctl;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.CNT_W(CW), .REG_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_req_a(id_req_a), .id_req_b(id_req_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b),
    .ex_regfile_w_en(ex_regfile_w_en), .ex_regfile_req_w(ex_regfile_req_w),
    .ex_r_datamem(ex_r_datamem),
    .mem_regfile_w_en(mem_regfile_w_en), .mem_regfile_req_w(mem_regfile_req_w),
    .mem_dmem_access(mem_dmem_access), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .halt(halt), .clr_stats(clr_stats),
    .pc_en(pc_en), .ps1_en(ps1_en), .ps2_en(ps2_en), .ps3_en(ps3_en), .ps4_en(ps4_en),
    .ps1_clear(ps1_clear), .ps2_clear(ps2_clear), .ps3_clear(ps3_clear), .ps4_clear(ps4_clear),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .freeze_cycles(freeze_cycles)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_en, ps1_en, ps2_en, ps3_en, ps4_en,
                ps1_clear, ps2_clear, ps3_clear, ps4_clear};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_req_a = '0; id_req_b = '0; id_use_a = 1'b0; id_use_b = 1'b0;
    ex_regfile_w_en = 1'b0; ex_regfile_req_w = '0; ex_r_datamem = 1'b0;
    mem_regfile_w_en = 1'b0; mem_regfile_req_w = '0;
    mem_dmem_access = 1'b0; dmem_ready = 1'b1;
    branch_taken = 1'b0; halt = 1'b0; clr_stats = 1'b0;
  endtask

  // Advance one clock; leaves time 1 after the edge so inputs can change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load in EX targeting r5 with ID reading r5 as A.
  task automatic set_load_use();
    ex_regfile_w_en = 1'b1; ex_regfile_req_w = 5'd5; ex_r_datamem = 1'b1;
    id_req_a = 5'd5; id_use_a = 1'b1;
  endtask

  // ALU result for r4 in EX with ID reading r4 as A (forwards from MEM).
  task automatic set_ex_fwd_a();
    ex_regfile_w_en = 1'b1; ex_regfile_req_w = 5'd4; ex_r_datamem = 1'b0;
    id_req_a = 5'd4; id_use_a = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    chk("reset_ctl", 32'(ctl), 32'(CTL_NONE));
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("reset_cnts", 32'({stall_cycles, flush_count}), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(CTL_NORMAL));
    tick();

    // Load-use stall, then the load sits in MEM and forwards from WB.
    set_load_use();
    #1;
    chk("lduse_ctl", 32'(ctl), 32'(CTL_LDUSE));
    tick();
    chk("lduse_stall", 32'(stall_cycles), 32'd1);
    chk("lduse_fwd_a", 32'(fwd_a), 32'd0);
    idle();
    mem_regfile_w_en = 1'b1; mem_regfile_req_w = 5'd5;
    id_req_a = 5'd5; id_use_a = 1'b1;
    #1;
    chk("ldmem_ctl", 32'(ctl), 32'(CTL_NORMAL));
    tick();
    chk("ldmem_fwd_a", 32'(fwd_a), 32'd2);
    chk("ldmem_stall", 32'(stall_cycles), 32'd1);

    // EX and MEM both write r3; EX is younger and wins.
    idle();
    ex_regfile_w_en = 1'b1; ex_regfile_req_w = 5'd3;
    mem_regfile_w_en = 1'b1; mem_regfile_req_w = 5'd3;
    id_req_b = 5'd3; id_use_b = 1'b1;
    id_req_a = 5'd7; id_use_a = 1'b1;
    #1;
    chk("exmem_ctl", 32'(ctl), 32'(CTL_NORMAL));
    tick();
    chk("exmem_fwd_b", 32'(fwd_b), 32'd1);
    chk("exmem_fwd_a", 32'(fwd_a), 32'd0);

    // Branch beats a simultaneous load-use hazard.
    idle();
    set_load_use();
    branch_taken = 1'b1;
    #1;
    chk("flush_ctl", 32'(ctl), 32'(CTL_FLUSH));
    tick();
    chk("flush_cnt", 32'(flush_count), 32'd1);
    chk("flush_stall", 32'(stall_cycles), 32'd1);
    chk("flush_fwd_b", 32'(fwd_b), 32'd0);

    // Prime fwd_a=1, then freeze for three cycles; fwd must hold.
    idle();
    set_ex_fwd_a();
    tick();
    chk("prime_fwd_a", 32'(fwd_a), 32'd1);
    idle();
    mem_dmem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("freeze_ctl_%0d", i), 32'(ctl), 32'(CTL_NONE));
      tick();
      chk($sformatf("freeze_fwd_%0d", i), 32'(fwd_a), 32'd1);
    end
    chk("freeze_cnt", 32'(freeze_cycles), 32'd3);
    dmem_ready = 1'b1;
    #1;
    chk("ready_ctl", 32'(ctl), 32'(CTL_NORMAL));
    tick();
    chk("ready_fwd_a", 32'(fwd_a), 32'd0);
    chk("ready_freeze_cnt", 32'(freeze_cycles), 32'd3);

    // Destination r0 never matches.
    idle();
    ex_regfile_w_en = 1'b1; ex_regfile_req_w = '0; ex_r_datamem = 1'b1;
    mem_regfile_w_en = 1'b1; mem_regfile_req_w = '0;
    id_use_a = 1'b1; id_use_b = 1'b1;
    #1;
    chk("r0_ctl", 32'(ctl), 32'(CTL_NORMAL));
    tick();
    chk("r0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("r0_stall", 32'(stall_cycles), 32'd1);

    // Clear wins over a same-cycle stall increment.
    idle();
    set_load_use();
    clr_stats = 1'b1;
    tick();
    chk("clr_stall", 32'(stall_cycles), 32'd0);
    chk("clr_flush", 32'(flush_count), 32'd0);
    chk("clr_freeze", 32'(freeze_cycles), 32'd0);

    // Saturation: 65535 stalls reach all-ones, one more stays there.
    clr_stats = 1'b0;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    chk("sat_reach", 32'(stall_cycles), 32'h0000_FFFF);
    tick();
    chk("sat_hold", 32'(stall_cycles), 32'h0000_FFFF);

    // Halt beats a freeze and is sticky.
    idle();
    set_ex_fwd_a();
    tick();
    chk("prehalt_fwd_a", 32'(fwd_a), 32'd1);
    idle();
    halt = 1'b1;
    mem_dmem_access = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("halt_ctl", 32'(ctl), 32'(CTL_NONE));
    tick();
    chk("halt_state", 32'(halted), 32'd1);
    chk("halt_no_freeze", 32'(freeze_cycles), 32'd0);
    idle();
    set_load_use();
    branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("halted_ctl_%0d", i), 32'(ctl), 32'(CTL_NONE));
      tick();
      chk($sformatf("halted_state_%0d", i), 32'(halted), 32'd1);
    end
    chk("halted_flush", 32'(flush_count), 32'd0);
    chk("halted_fwd_a", 32'(fwd_a), 32'd1);

    // Asynchronous reset out of HALTED.
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl), 32'(CTL_NONE));
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    idle();
    rst_n = 1'b1;
    #1;
    chk("rst_release_ctl", 32'(ctl), 32'(CTL_NORMAL));
    tick();

    // Reset in the middle of a freeze.
    set_ex_fwd_a();
    tick();
    idle();
    mem_dmem_access = 1'b1; dmem_ready = 1'b0;
    tick();
    chk("midfrz_cnt", 32'(freeze_cycles), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midfrz_rst_cnt", 32'(freeze_cycles), 32'd0);
    chk("midfrz_rst_fwd", 32'(fwd_a), 32'd0);
    chk("midfrz_rst_ctl", 32'(ctl), 32'(CTL_NONE));
    idle();
    rst_n = 1'b1;
    tick();
    chk("midfrz_resume_ctl", 32'(ctl), 32'(CTL_NORMAL));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
